dllp_rx_decode: RTL and testbench
=================================

# dllp_rx_decode

Receive-side DLLP decoder for the PCIe data link layer. Accepts raw 6-byte DLLPs from the physical-layer framing stage, checks the 16-bit DLLP CRC, and decodes Ack/Nak, InitFC1/InitFC2/UpdateFC and PM DLLPs into field-level event pulses. Its outputs feed the flow-control init FSM (INIT_FC1 … INIT_FC_COMPLETE) and the replay/ack-nak tracker.

## Interface
- CNT_WIDTH, 16, width of each statistics counter.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_dllp_data  in  48  DLLP: [7:0] type, [15:8] byte1, [23:16] byte2, [31:24] byte3, [47:32] CRC.
- s_dllp_valid  in  1  DLLP valid.
- s_dllp_ready  out  1  DLLP accepted when valid && ready.
- dl_status  in  2  link state: 0 DL_DOWN, 1 DL_UP, 2 DL_ACTIVE.
- ack_valid  out  1  one-cycle pulse, Ack/Nak decoded.
- ack_is_nak  out  1  0 Ack, 1 Nak.
- ack_seq  out  12  {byte2[3:0], byte3}.
- fc_valid  out  1  one-cycle pulse, FC DLLP decoded.
- fc_phase  out  2  0 InitFC1, 1 InitFC2, 2 UpdateFC.
- fc_kind  out  2  0 P, 1 NP, 2 Cpl.
- fc_hdr  out  8  {byte1[5:0], byte2[7:6]}.
- fc_data  out  12  {byte2[3:0], byte3}.
- pm_valid  out  1  one-cycle pulse, PM DLLP decoded.
- pm_type  out  8  type byte of the PM DLLP.
- crc_err  out  1  one-cycle pulse, CRC mismatch.
- drop  out  1  one-cycle pulse, CRC-good DLLP discarded (unknown type, VC≠0, state gating).

## Operation
- Stage 1 (accept): on valid && ready, register s_dllp_data and dl_status; compute CRC-16 over bytes 0..3 (poly 0x100B, seed 0xFFFF, byte 0 first, bits LSB-first, result complemented and bit-mapped per PCIe DLLP CRC rules) and register the compare result.
- Stage 2 (decode): classify registered type byte:
  - 0x00 Ack, 0x10 Nak: ack_valid pulse, only in DL_ACTIVE; otherwise drop.
  - 0x4x/0x5x/0x6x InitFC1 P/NP/Cpl; 0xCx/0xDx/0xEx InitFC2; 0x8x/0x9x/0xAx UpdateFC. VC = type[2:0]; type[3] must be 0. Only VC0 decoded; other VC → drop. InitFC accepted in DL_UP or DL_ACTIVE; UpdateFC only in DL_ACTIVE; otherwise drop.
  - 0x20, 0x21, 0x23, 0x24 PM: pm_valid, only in DL_ACTIVE; otherwise drop.
  - 0x30 vendor-specific and all other codes: drop.
- CRC mismatch: crc_err pulse; no decode pulse, no drop pulse.
- dl_status is sampled at accept; a later change does not affect an in-flight DLLP.
- DL_DOWN: every CRC-good DLLP is dropped.
- Exactly one of ack_valid/fc_valid/pm_valid/crc_err/drop pulses per accepted DLLP.
- Field outputs hold last decoded value between pulses.

## Timing
- s_dllp_ready = !rst; one DLLP per cycle, back-to-back, no bubbles.
- Latency: DLLP accepted at edge N → result pulse high during cycle after edge N+1 (2 cycles).
- Reset: all pulses 0, ack_is_nak 0, ack_seq 0, fc_phase 0, fc_kind 0, fc_hdr 0, fc_data 0, pm_type 0, counters 0, pipeline valids cleared. Reset mid-operation discards both stages; no pulse emitted for in-flight DLLPs.

## Configuration
- DLLP_RX_STATS_EN defined: adds outputs crc_err_cnt, drop_cnt, ack_cnt, nak_cnt (each CNT_WIDTH, saturating at all-ones, cleared by rst), incremented on the cycle of the matching pulse.
- Undefined: ports and counters absent; decode behaviour identical.

## Test plan
- DL_ACTIVE, Ack seq 0x123 with good CRC → ack_valid 2 cycles later, ack_is_nak 0, ack_seq 0x123; Nak seq 0xFFF → ack_is_nak 1, ack_seq 0xFFF.
- DL_UP, InitFC1_P hdr 0x01 data 0x040 then InitFC2_NP hdr 0x01 data 0x010, back-to-back → fc_valid on consecutive cycles, (phase 0, kind 0, 0x01, 0x040) then (1, 1, 0x01, 0x010).
- Ack with CRC bit 0 flipped → crc_err pulse only; with stats, crc_err_cnt = 1.
- DL_UP: Ack and UpdateFC_P → drop each; DL_DOWN InitFC1_Cpl → drop; InitFC1_P with VC=1 → drop.
- PM_Enter_L1 (0x20) in DL_ACTIVE → pm_valid, pm_type 0x20; 0x30 → drop.
- rst asserted 1 cycle after accepting an Ack → no ack_valid; all outputs at reset values; ready returns high after rst deasserts.

Source files
------------

// File: rtl/dllp_rx_decode.sv
// -----------------------------------------------------------------------------
// dllp_rx_decode
// Receive-side PCIe DLLP decoder. Accepts one 6-byte DLLP per cycle, checks its
// 16-bit CRC, and turns Ack/Nak, InitFC1/InitFC2/UpdateFC and PM DLLPs into
// registered one-cycle event pulses with held field outputs. Two-stage pipeline:
// stage 1 registers the DLLP, the link state and the CRC compare; stage 2
// classifies and registers the result (pulse two cycles after accept).
//
// Optional build macro: DLLP_RX_STATS_EN adds saturating event counters
// (crc_err_cnt, drop_cnt, ack_cnt, nak_cnt).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_dllp_data       {CRC[15:0], byte3, byte2, byte1, type}
//   s_dllp_valid/ready DLLP handshake; ready = !rst
//   dl_status         0 DL_DOWN, 1 DL_UP, 2 DL_ACTIVE (sampled at accept)
//   ack_valid/ack_is_nak/ack_seq            Ack/Nak event + fields
//   fc_valid/fc_phase/fc_kind/fc_hdr/fc_data FC event + fields
//   pm_valid/pm_type                         PM event + type byte
//   crc_err, drop                            CRC failure / discarded DLLP
//   *_cnt (DLLP_RX_STATS_EN only)            CNT_WIDTH event counters
// -----------------------------------------------------------------------------
module dllp_rx_decode #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [47:0]          s_dllp_data,
   input  logic                 s_dllp_valid,
   output logic                 s_dllp_ready,
   input  logic [1:0]           dl_status,
   output logic                 ack_valid,
   output logic                 ack_is_nak,
   output logic [11:0]          ack_seq,
   output logic                 fc_valid,
   output logic [1:0]           fc_phase,
   output logic [1:0]           fc_kind,
   output logic [7:0]           fc_hdr,
   output logic [11:0]          fc_data,
   output logic                 pm_valid,
   output logic [7:0]           pm_type,
   output logic                 crc_err,
`ifdef DLLP_RX_STATS_EN
   output logic [CNT_WIDTH-1:0] crc_err_cnt,
   output logic [CNT_WIDTH-1:0] drop_cnt,
   output logic [CNT_WIDTH-1:0] ack_cnt,
   output logic [CNT_WIDTH-1:0] nak_cnt,
`endif
   output logic                 drop
);

   localparam logic [1:0]  DL_DOWN   = 2'd0;
   localparam logic [1:0]  DL_UP     = 2'd1;
   localparam logic [1:0]  DL_ACTIVE = 2'd2;
   localparam logic [15:0] CRC_POLY  = 16'h100B;
   localparam logic [15:0] CRC_SEED  = 16'hFFFF;

   localparam logic [1:0]  PH_INIT1  = 2'd0;
   localparam logic [1:0]  PH_INIT2  = 2'd1;
   localparam logic [1:0]  PH_UPDATE = 2'd2;

   typedef enum logic [2:0] {
      EV_NONE = 3'd0,
      EV_ACK  = 3'd1,
      EV_FC   = 3'd2,
      EV_PM   = 3'd3,
      EV_CRC  = 3'd4,
      EV_DROP = 3'd5
   } ev_e;

   // DLLP CRC over bytes 0..3: serial LFSR fed bit 0 of byte 0 first; the
   // complemented remainder is bit-reversed so CRC bit 15 lands in byte 4 bit 0.
   function automatic logic [15:0] dllp_crc_field(input logic [31:0] d);
      logic [15:0] c;
      logic [15:0] f;
      logic        fb;
      c = CRC_SEED;
      for (int i = 0; i < 32; i++) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
      c = ~c;
      for (int k = 0; k < 16; k++) begin
         f[k] = c[15-k];
      end
      return f;
   endfunction

   // Stage 1 registers
   logic        s1_valid_q;
   logic [7:0]  s1_type_q;
   logic [7:0]  s1_hdr_q;
   logic [11:0] s1_seq_q;
   logic [1:0]  s1_status_q;
   logic        s1_crc_ok_q;

   // Stage 2 decode (combinational) and registered outputs
   ev_e         ev_d;
   logic        nak_d;
   logic [1:0]  phase_d;
   logic [1:0]  kind_d;

   logic        ack_valid_q, fc_valid_q, pm_valid_q, crc_err_q, drop_q;
   logic        ack_is_nak_q;
   logic [11:0] ack_seq_q;
   logic [1:0]  fc_phase_q, fc_kind_q;
   logic [7:0]  fc_hdr_q;
   logic [11:0] fc_data_q;
   logic [7:0]  pm_type_q;

   logic        accept;

   assign s_dllp_ready = ~rst;
   assign accept       = s_dllp_valid & s_dllp_ready;

   // Stage 1: capture DLLP fields, link state and CRC verdict
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_type_q   <= 8'h00;
         s1_hdr_q    <= 8'h00;
         s1_seq_q    <= 12'h000;
         s1_status_q <= DL_DOWN;
         s1_crc_ok_q <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_type_q   <= s_dllp_data[7:0];
            s1_hdr_q    <= {s_dllp_data[13:8], s_dllp_data[23:22]};
            s1_seq_q    <= {s_dllp_data[19:16], s_dllp_data[31:24]};
            s1_status_q <= dl_status;
            s1_crc_ok_q <= (dllp_crc_field(s_dllp_data[31:0]) == s_dllp_data[47:32]);
         end
      end
   end

   // Stage 2: classify the registered type byte into exactly one event
   always_comb begin
      logic       active;
      logic       up_or_active;
      logic       fc_code;
      logic       pm_code;
      logic [7:0] t;

      ev_d    = EV_NONE;
      nak_d   = 1'b0;
      phase_d = PH_INIT1;
      kind_d  = 2'd0;

      t            = s1_type_q;
      active       = (s1_status_q == DL_ACTIVE);
      up_or_active = (s1_status_q == DL_UP) || active;
      // FC codes: type[7:6] != 00 selects phase, type[5:4] != 11 selects kind,
      // type[3] is reserved-zero.
      fc_code      = (t[7:6] != 2'b00) && (t[5:4] != 2'b11) && !t[3];
      pm_code      = (t == 8'h20) || (t == 8'h21) || (t == 8'h23) || (t == 8'h24);

      unique case (t[7:6])
         2'b01:   phase_d = PH_INIT1;
         2'b11:   phase_d = PH_INIT2;
         default: phase_d = PH_UPDATE;
      endcase
      kind_d = t[5:4];
      nak_d  = t[4];

      if (s1_valid_q) begin
         if (!s1_crc_ok_q) begin
            ev_d = EV_CRC;
         end else if ((t == 8'h00) || (t == 8'h10)) begin
            ev_d = active ? EV_ACK : EV_DROP;
         end else if (fc_code) begin
            if (t[2:0] != 3'd0) begin
               ev_d = EV_DROP;
            end else if (phase_d == PH_UPDATE) begin
               ev_d = active ? EV_FC : EV_DROP;
            end else begin
               ev_d = up_or_active ? EV_FC : EV_DROP;
            end
         end else if (pm_code) begin
            ev_d = active ? EV_PM : EV_DROP;
         end else begin
            ev_d = EV_DROP;
         end
      end
   end

   // Stage 2 registers: pulses every cycle, fields only on their own event
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_valid_q  <= 1'b0;
         fc_valid_q   <= 1'b0;
         pm_valid_q   <= 1'b0;
         crc_err_q    <= 1'b0;
         drop_q       <= 1'b0;
         ack_is_nak_q <= 1'b0;
         ack_seq_q    <= 12'h000;
         fc_phase_q   <= 2'd0;
         fc_kind_q    <= 2'd0;
         fc_hdr_q     <= 8'h00;
         fc_data_q    <= 12'h000;
         pm_type_q    <= 8'h00;
      end else begin
         ack_valid_q <= (ev_d == EV_ACK);
         fc_valid_q  <= (ev_d == EV_FC);
         pm_valid_q  <= (ev_d == EV_PM);
         crc_err_q   <= (ev_d == EV_CRC);
         drop_q      <= (ev_d == EV_DROP);
         if (ev_d == EV_ACK) begin
            ack_is_nak_q <= nak_d;
            ack_seq_q    <= s1_seq_q;
         end
         if (ev_d == EV_FC) begin
            fc_phase_q <= phase_d;
            fc_kind_q  <= kind_d;
            fc_hdr_q   <= s1_hdr_q;
            fc_data_q  <= s1_seq_q;
         end
         if (ev_d == EV_PM) begin
            pm_type_q <= s1_type_q;
         end
      end
   end

   assign ack_valid  = ack_valid_q;
   assign ack_is_nak = ack_is_nak_q;
   assign ack_seq    = ack_seq_q;
   assign fc_valid   = fc_valid_q;
   assign fc_phase   = fc_phase_q;
   assign fc_kind    = fc_kind_q;
   assign fc_hdr     = fc_hdr_q;
   assign fc_data    = fc_data_q;
   assign pm_valid   = pm_valid_q;
   assign pm_type    = pm_type_q;
   assign crc_err    = crc_err_q;
   assign drop       = drop_q;

`ifdef DLLP_RX_STATS_EN
   logic [CNT_WIDTH-1:0] crc_err_cnt_q, drop_cnt_q, ack_cnt_q, nak_cnt_q;

   // Saturating counters, stepping on the same edge that raises the pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_err_cnt_q <= '0;
         drop_cnt_q    <= '0;
         ack_cnt_q     <= '0;
         nak_cnt_q     <= '0;
      end else begin
         if ((ev_d == EV_CRC) && (crc_err_cnt_q != '1)) begin
            crc_err_cnt_q <= crc_err_cnt_q + CNT_WIDTH'(1);
         end
         if ((ev_d == EV_DROP) && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
         end
         if ((ev_d == EV_ACK) && !nak_d && (ack_cnt_q != '1)) begin
            ack_cnt_q <= ack_cnt_q + CNT_WIDTH'(1);
         end
         if ((ev_d == EV_ACK) && nak_d && (nak_cnt_q != '1)) begin
            nak_cnt_q <= nak_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   assign crc_err_cnt = crc_err_cnt_q;
   assign drop_cnt    = drop_cnt_q;
   assign ack_cnt     = ack_cnt_q;
   assign nak_cnt     = nak_cnt_q;
`endif

endmodule

// File: tb/tb_dllp_rx_decode.sv
// -----------------------------------------------------------------------------
// tb_dllp_rx_decode
// Table of DLLP vectors with their expected event and fields, driven
// back-to-back; a scoreboard queue holds each expectation with its due cycle
// and a negedge monitor compares pulses and held fields. Hand-written
// sequences cover in-flight link-state changes and mid-pipeline reset.
// -----------------------------------------------------------------------------
module tb_dllp_rx_decode;

   localparam int unsigned CNT_WIDTH = 16;
   localparam logic [1:0] DN = 2'd0, UP = 2'd1, AC = 2'd2;
   localparam int EV_ACK = 1, EV_FC = 2, EV_PM = 3, EV_CRC = 4, EV_DROP = 5;
   localparam int NV = 17;

   typedef struct {
      logic [7:0]  typ, b1, b2, b3;
      logic [1:0]  st;
      logic        bad_crc;
      int          ev;
      logic        nak;
      logic [11:0] seq;
      logic [1:0]  ph, kd;
      logic [7:0]  hdr;
      logic [11:0] dat;
      logic [7:0]  pmt;
   } vec_t;

   typedef struct {
      vec_t v;
      int   due;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] s_dllp_data;
   logic        s_dllp_valid;
   logic        s_dllp_ready;
   logic [1:0]  dl_status;
   logic        ack_valid, ack_is_nak, fc_valid, pm_valid, crc_err, drop;
   logic [11:0] ack_seq, fc_data;
   logic [1:0]  fc_phase, fc_kind;
   logic [7:0]  fc_hdr, pm_type;
`ifdef DLLP_RX_STATS_EN
   logic [CNT_WIDTH-1:0] crc_err_cnt, drop_cnt, ack_cnt, nak_cnt;
   int m_crc_n = 0, m_drop_n = 0, m_ack_n = 0, m_nak_n = 0;
`endif

   dllp_rx_decode #(.CNT_WIDTH(CNT_WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_dllp_data  (s_dllp_data),
      .s_dllp_valid (s_dllp_valid),
      .s_dllp_ready (s_dllp_ready),
      .dl_status    (dl_status),
      .ack_valid    (ack_valid),
      .ack_is_nak   (ack_is_nak),
      .ack_seq      (ack_seq),
      .fc_valid     (fc_valid),
      .fc_phase     (fc_phase),
      .fc_kind      (fc_kind),
      .fc_hdr       (fc_hdr),
      .fc_data      (fc_data),
      .pm_valid     (pm_valid),
      .pm_type      (pm_type),
      .crc_err      (crc_err),
`ifdef DLLP_RX_STATS_EN
      .crc_err_cnt  (crc_err_cnt),
      .drop_cnt     (drop_cnt),
      .ack_cnt      (ack_cnt),
      .nak_cnt      (nak_cnt),
`endif
      .drop         (drop)
   );

   always #5 clk = ~clk;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;
   bit  mon_en = 1'b0;
   sb_t sbq[$];
   vec_t vecs[NV];

   // Held-field model
   logic        m_nak = 1'b0;
   logic [11:0] m_seq = 12'h0, m_dat = 12'h0;
   logic [1:0]  m_ph = 2'd0, m_kd = 2'd0;
   logic [7:0]  m_hdr = 8'h0, m_pmt = 8'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   // Byte-wise CRC-16/0x100B: reflected bytes fed MSB-first into the register
   function automatic logic [15:0] crc_field(input logic [7:0] b0, b1, b2, b3);
      logic [15:0] c;
      logic [7:0]  bytes [4];
      bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
      c = 16'hFFFF;
      for (int n = 0; n < 4; n++) begin
         c = c ^ {rev8(bytes[n]), 8'h00};
         for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h100B) : (c << 1);
      end
      c = ~c;
      return {rev8(c[7:0]), rev8(c[15:8])};
   endfunction

   function automatic vec_t mk(input logic [7:0] typ, b1, b2, b3, input logic [1:0] st,
                               input logic bad, input int ev, input logic nak,
                               input logic [11:0] seq, input logic [1:0] ph, kd,
                               input logic [7:0] hdr, input logic [11:0] dat,
                               input logic [7:0] pmt);
      vec_t v;
      v.typ = typ; v.b1 = b1; v.b2 = b2; v.b3 = b3; v.st = st; v.bad_crc = bad;
      v.ev = ev; v.nak = nak; v.seq = seq; v.ph = ph; v.kd = kd;
      v.hdr = hdr; v.dat = dat; v.pmt = pmt;
      return v;
   endfunction

   // Drive one DLLP for one cycle; optionally record its expected result
   task automatic send(input vec_t v, input bit expect_it);
      logic [15:0] c;
      sb_t e;
      @(posedge clk);
      #1;
      c = crc_field(v.typ, v.b1, v.b2, v.b3);
      if (v.bad_crc) c[0] = ~c[0];
      s_dllp_data  = {c, v.b3, v.b2, v.b1, v.typ};
      s_dllp_valid = 1'b1;
      dl_status    = v.st;
      if (expect_it) begin
         e.v   = v;
         e.due = cyc + 2;
         sbq.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      s_dllp_valid = 1'b0;
      s_dllp_data  = 48'h0;
      repeat (n - 1) @(posedge clk);
   endtask

   // Monitor: compare pulses every cycle, fields whenever a result is due
   always @(negedge clk) begin
      logic [4:0] pulses, exp_p;
      sb_t e;
      if (mon_en) begin
         pulses = {ack_valid, fc_valid, pm_valid, crc_err, drop};
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            exp_p = 5'b0;
            case (e.v.ev)
               EV_ACK: begin
                  exp_p = 5'b10000; m_nak = e.v.nak; m_seq = e.v.seq;
`ifdef DLLP_RX_STATS_EN
                  if (e.v.nak) m_nak_n++; else m_ack_n++;
`endif
               end
               EV_FC: begin
                  exp_p = 5'b01000; m_ph = e.v.ph; m_kd = e.v.kd;
                  m_hdr = e.v.hdr; m_dat = e.v.dat;
               end
               EV_PM:  begin exp_p = 5'b00100; m_pmt = e.v.pmt; end
               EV_CRC: begin
                  exp_p = 5'b00010;
`ifdef DLLP_RX_STATS_EN
                  m_crc_n++;
`endif
               end
               default: begin
                  exp_p = 5'b00001;
`ifdef DLLP_RX_STATS_EN
                  m_drop_n++;
`endif
               end
            endcase
            check($sformatf("pulses type=%02h st=%0d", e.v.typ, e.v.st), 64'(pulses), 64'(exp_p));
            check($sformatf("fields type=%02h", e.v.typ),
                  64'({ack_is_nak, ack_seq, fc_phase, fc_kind, fc_hdr, fc_data, pm_type}),
                  64'({m_nak, m_seq, m_ph, m_kd, m_hdr, m_dat, m_pmt}));
         end else if (pulses != 5'b0) begin
            check("unexpected_pulse", 64'(pulses), 64'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //          type   b1     b2     b3     st bad ev       nak seq     ph kd hdr    dat     pmt
      vecs[0]  = mk(8'h00, 8'h00, 8'h01, 8'h23, AC, 0, EV_ACK,  1'b0, 12'h123, 0, 0, 8'h00, 12'h000, 8'h00);
      vecs[1]  = mk(8'h10, 8'h00, 8'h0F, 8'hFF, AC, 0, EV_ACK,  1'b1, 12'hFFF, 0, 0, 8'h00, 12'h000, 8'h00);
      vecs[2]  = mk(8'h40, 8'h00, 8'h40, 8'h40, UP, 0, EV_FC,   1'b0, 12'h000, 0, 0, 8'h01, 12'h040, 8'h00);
      vecs[3]  = mk(8'hD0, 8'h00, 8'h40, 8'h10, UP, 0, EV_FC,   1'b0, 12'h000, 1, 1, 8'h01, 12'h010, 8'h00);
      vecs[4]  = mk(8'h00, 8'h00, 8'h01, 8'h23, AC, 1, EV_CRC,  1'b0, 12'h000, 0, 0, 8'h00, 12'h000, 8'h00);
      vecs[5]  = mk(8'h00, 8'h00, 8'h02, 8'h34, UP, 0, EV_DROP, 1'b0, 12'h000, 0, 0, 8'h00, 12'h000, 8'h00);
      vecs[6]  = mk(8'h80, 8'h01, 8'h00, 8'h20, UP, 0, EV_DROP, 1'b0, 12'h000, 0, 0, 8'h00, 12'h000, 8'h00);
      vecs[7]  = mk(8'h60, 8'h01, 8'h00, 8'h20, DN, 0, EV_DROP, 1'b0, 12'h000, 0, 0, 8'h00, 12'h000, 8'h00);
      vecs[8]  = mk(8'h41, 8'h00, 8'h40, 8'h40, UP, 0, EV_DROP, 1'b0, 12'h000, 0, 0, 8'h00, 12'h000, 8'h00);
      vecs[9]  = mk(8'h20, 8'h00, 8'h00, 8'h00, AC, 0, EV_PM,   1'b0, 12'h000, 0, 0, 8'h00, 12'h000, 8'h20);
      vecs[10] = mk(8'h30, 8'h00, 8'h00, 8'h00, AC, 0, EV_DROP, 1'b0, 12'h000, 0, 0, 8'h00, 12'h000, 8'h00);
      vecs[11] = mk(8'hA0, 8'h3F, 8'hCA, 8'hBC, AC, 0, EV_FC,   1'b0, 12'h000, 2, 2, 8'hFF, 12'hABC, 8'h00);
      vecs[12] = mk(8'h48, 8'h00, 8'h40, 8'h40, UP, 0, EV_DROP, 1'b0, 12'h000, 0, 0, 8'h00, 12'h000, 8'h00);
      vecs[13] = mk(8'h24, 8'h00, 8'h00, 8'h00, AC, 0, EV_PM,   1'b0, 12'h000, 0, 0, 8'h00, 12'h000, 8'h24);
      vecs[14] = mk(8'h22, 8'h00, 8'h00, 8'h00, AC, 0, EV_DROP, 1'b0, 12'h000, 0, 0, 8'h00, 12'h000, 8'h00);
      vecs[15] = mk(8'h50, 8'h20, 8'h07, 8'hFF, AC, 0, EV_FC,   1'b0, 12'h000, 0, 1, 8'h80, 12'h7FF, 8'h00);
      vecs[16] = mk(8'h00, 8'h00, 8'h05, 8'h55, 2'd3, 0, EV_DROP, 1'b0, 12'h000, 0, 0, 8'h00, 12'h000, 8'h00);

      rst = 1'b1; s_dllp_valid = 1'b0; s_dllp_data = 48'h0; dl_status = DN;
      repeat (3) @(posedge clk);
      #1;
      check("ready_in_reset", 64'(s_dllp_ready), 64'd0);
      check("outputs_after_reset",
            64'({ack_valid, fc_valid, pm_valid, crc_err, drop, ack_is_nak, ack_seq,
                 fc_phase, fc_kind, fc_hdr, fc_data, pm_type}), 64'd0);
      rst = 1'b0;
      #1;
      check("ready_after_reset", 64'(s_dllp_ready), 64'd1);
      mon_en = 1'b1;

      // Table vectors back-to-back, one per cycle
      for (int i = 0; i < NV; i++) send(vecs[i], 1'b1);
      idle(4);

      // Link state changes after accept must not affect the in-flight DLLP
      send(mk(8'h00, 8'h00, 8'h00, 8'h05, AC, 0, EV_ACK, 1'b0, 12'h005, 0, 0, 8'h0, 12'h0, 8'h0), 1'b1);
      @(posedge clk); #1; s_dllp_valid = 1'b0; dl_status = DN;
      repeat (3) @(posedge clk);
      send(mk(8'h10, 8'h00, 8'h07, 8'h77, AC, 0, EV_ACK, 1'b1, 12'h777, 0, 0, 8'h0, 12'h0, 8'h0), 1'b1);
      send(mk(8'h10, 8'h00, 8'h01, 8'h11, DN, 0, EV_DROP, 1'b0, 12'h0, 0, 0, 8'h0, 12'h0, 8'h0), 1'b1);
      idle(4);

      // Reset one cycle after accepting an Ack: no pulse, fields cleared
      send(mk(8'h00, 8'h00, 8'h09, 8'h99, AC, 0, EV_ACK, 1'b0, 12'h999, 0, 0, 8'h0, 12'h0, 8'h0), 1'b0);
      @(posedge clk); #1;
      s_dllp_valid = 1'b0; rst = 1'b1;
      #1;
      check("ready_low_mid_reset", 64'(s_dllp_ready), 64'd0);
      @(posedge clk); #1;
      m_nak = 1'b0; m_seq = 12'h0; m_ph = 2'd0; m_kd = 2'd0; m_hdr = 8'h0; m_dat = 12'h0; m_pmt = 8'h0;
      check("outputs_mid_reset",
            64'({ack_valid, fc_valid, pm_valid, crc_err, drop, ack_is_nak, ack_seq,
                 fc_phase, fc_kind, fc_hdr, fc_data, pm_type}), 64'd0);
`ifdef DLLP_RX_STATS_EN
      check("counters_mid_reset", 64'({crc_err_cnt, drop_cnt, ack_cnt, nak_cnt}), 64'd0);
      m_crc_n = 0; m_drop_n = 0; m_ack_n = 0; m_nak_n = 0;
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("ready_after_mid_reset", 64'(s_dllp_ready), 64'd1);
      repeat (3) @(posedge clk);

      // Post-reset traffic: CRC error then a good Ack
      send(vecs[4], 1'b1);
      send(vecs[0], 1'b1);
      idle(5);

      check("scoreboard_drained", 64'(sbq.size()), 64'd0);
`ifdef DLLP_RX_STATS_EN
      check("crc_err_cnt", 64'(crc_err_cnt), 64'(m_crc_n));
      check("drop_cnt",    64'(drop_cnt),    64'(m_drop_n));
      check("ack_cnt",     64'(ack_cnt),     64'(m_ack_n));
      check("nak_cnt",     64'(nak_cnt),     64'(m_nak_n));
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
